// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the pipeline-control slice.
//   FSM state codes, pc_sel mux codes, default interrupt vector.
package pipe_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_TRAP     = 2'd2;

  localparam logic [1:0] PC_SEQ   = 2'd0;  // PC+4
  localparam logic [1:0] PC_REDIR = 2'd1;  // redirect_pc
  localparam logic [1:0] PC_TRAP  = 2'd2;  // trap vector
  localparam logic [1:0] PC_EPC   = 2'd3;  // saved epc

  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
endpackage

// File: rtl/pipe_wait_timer.sv
// pipe_wait_timer: bus-wait cycle counter.
//   gclk, grst_n : clock, async active-low reset
//   start        : load 1 (first wait cycle)
//   inc          : count one more wait cycle, saturates at WAIT_MAX
//   clr          : back to 0 (wins over start/inc)
//   expire       : count has reached WAIT_MAX
module pipe_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic start,
  input  logic inc,
  input  logic clr,
  output logic expire
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                             cnt <= '0;
    else if (clr)                            cnt <= '0;
    else if (start)                          cnt <= CW'(1);
    else if (inc && cnt != CW'(WAIT_MAX))    cnt <= cnt + CW'(1);
  end

  assign expire = (cnt == CW'(WAIT_MAX));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage-register enables/flushes, PC steering and interrupt
// entry/return for the pipelined RV32 core.
//   clk, reset       : clock, async active-low reset
//   load_use_hzd     : load-use stall request
//   redirect_valid/pc: taken branch/jump from EX
//   mret_valid       : return-from-interrupt in EX
//   ex_valid, ex_pc  : EX occupancy and PC (epc source)
//   mem_req, MIO_ready : MEM bus handshake
//   INT              : level interrupt request
//   stage_en/flush   : per-register enable / clear (clear wins), 0 = PC
//   pc_sel/pc_target : PC mux select and non-sequential target
//   epc, int_active  : saved return PC, in-handler flag
//   int_ack, bus_err : one-cycle registered pulses
module pipe_ctrl import pipe_pkg::*; #(
  parameter int              XLEN       = 32,
  parameter int              NUM_STAGES = 5,
  parameter int              DEC_STAGE  = 1,
  parameter int              MEM_STAGE  = 3,
  parameter logic [XLEN-1:0] TRAP_VEC   = TRAP_VEC_DEF,
  parameter int              WAIT_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_use_hzd,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  mret_valid,
  input  logic                  ex_valid,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic                  mem_req,
  input  logic                  MIO_ready,
  input  logic                  INT,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [1:0]            pc_sel,
  output logic [XLEN-1:0]       pc_target,
  output logic [XLEN-1:0]       epc,
  output logic                  int_active,
  output logic                  int_ack,
  output logic                  bus_err
);
  state_t state_q, state_d;
  logic   tmr_start, tmr_inc, tmr_clr, tmr_expire;
  logic   accept, mret_take, timeout;

  // Static stage masks derived from the pipeline geometry.
  logic [NUM_STAGES-1:0] hold_mem, bub_mem, fl_dec, hold_dec, bub_dec;
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_mask
    assign hold_mem[g] = (g <= MEM_STAGE);
    assign bub_mem[g]  = (g == MEM_STAGE + 1);
    assign fl_dec[g]   = (g >= 1) && (g <= DEC_STAGE + 1);
    assign hold_dec[g] = (g <= DEC_STAGE);
    assign bub_dec[g]  = (g == DEC_STAGE + 1);
  end

  logic bus_wait, mret_go, int_go;
  assign bus_wait = mem_req & ~MIO_ready;
  assign mret_go  = mret_valid & int_active;     // mret outside a handler is a NOP
  assign int_go   = INT & ~int_active & ex_valid;

  always_comb begin
    stage_en    = '1;
    stage_flush = '0;
    pc_sel      = PC_SEQ;
    pc_target   = '0;
    state_d     = state_q;
    tmr_start   = 1'b0;
    tmr_inc     = 1'b0;
    tmr_clr     = 1'b0;
    accept      = 1'b0;
    mret_take   = 1'b0;
    timeout     = 1'b0;
    if (!reset) begin
      stage_en    = '0;
      stage_flush = '1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus_wait) begin
            // EX is frozen, so redirect/mret/INT re-present after the wait.
            stage_en    = ~hold_mem;
            stage_flush = bub_mem;
            tmr_start   = 1'b1;
            state_d     = ST_MEM_WAIT;
          end else if (redirect_valid) begin
            stage_flush = fl_dec;
            pc_sel      = PC_REDIR;
            pc_target   = redirect_pc;
          end else if (mret_go) begin
            stage_flush = fl_dec;
            pc_sel      = PC_EPC;
            pc_target   = epc;
            mret_take   = 1'b1;
          end else if (int_go) begin
            // PC holds this cycle; the vector is steered in from TRAP.
            stage_flush = fl_dec;
            stage_en[0] = 1'b0;
            accept      = 1'b1;
            state_d     = ST_TRAP;
          end else if (load_use_hzd) begin
            stage_en    = ~hold_dec;
            stage_flush = bub_dec;
          end
        end
        ST_MEM_WAIT: begin
          if (MIO_ready) begin
            tmr_clr = 1'b1;
            state_d = ST_RUN;
          end else if (tmr_expire) begin
            // Give up on the bus: release everything and flag the error.
            timeout = 1'b1;
            tmr_clr = 1'b1;
            state_d = ST_RUN;
          end else begin
            stage_en    = ~hold_mem;
            stage_flush = bub_mem;
            tmr_inc     = 1'b1;
          end
        end
        ST_TRAP: begin
          pc_sel         = PC_TRAP;
          pc_target      = TRAP_VEC;
          stage_flush[1] = 1'b1;
          state_d        = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      epc        <= '0;
      int_active <= 1'b0;
      int_ack    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      int_ack <= accept;
      bus_err <= timeout;
      if (accept) begin
        epc        <= ex_pc;
        int_active <= 1'b1;
      end else if (mret_take) begin
        int_active <= 1'b0;
      end
    end
  end

  pipe_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .gclk   (clk),
    .grst_n (reset),
    .start  (tmr_start),
    .inc    (tmr_inc),
    .clr    (tmr_clr),
    .expire (tmr_expire)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int NS   = 5;
  localparam int DEC  = 1;
  localparam int MEMS = 3;
  localparam int WMAX = 16;
  localparam logic [31:0] TVEC = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_use_hzd, redirect_valid, mret_valid, ex_valid;
  logic          mem_req, MIO_ready, INT;
  logic [31:0]   redirect_pc, ex_pc;
  logic [NS-1:0] stage_en, stage_flush;
  logic [1:0]    pc_sel;
  logic [31:0]   pc_target, epc;
  logic          int_active, int_ack, bus_err;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .load_use_hzd(load_use_hzd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mret_valid(mret_valid), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .mem_req(mem_req), .MIO_ready(MIO_ready), .INT(INT),
    .stage_en(stage_en), .stage_flush(stage_flush), .pc_sel(pc_sel),
    .pc_target(pc_target), .epc(epc), .int_active(int_active),
    .int_ack(int_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] rng(int lo, int hi);
    logic [NS-1:0] m = '0;
    for (int i = 0; i < NS; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
    return m;
  endfunction

  // ---------------- behavioural model ----------------
  // m_held: bus-wait cycles held so far (0 = no wait in progress)
  int          m_held = 0;
  bit          m_trap = 0, m_act = 0, m_ack = 0, m_err = 0;
  logic [31:0] m_epc = '0;

  always @(negedge clk) begin
    logic [NS-1:0] e_en, e_fl;
    logic [1:0]    e_sel;
    logic [31:0]   e_tgt;
    int            n_held;
    bit            n_trap, n_act, acc, tmo;
    logic [31:0]   n_epc;
    e_en = '1; e_fl = '0; e_sel = 2'd0; e_tgt = '0;
    n_held = 0; n_trap = 0; n_act = m_act; n_epc = m_epc; acc = 0; tmo = 0;
    if (!reset) begin
      e_en = '0; e_fl = '1;
      m_held = 0; m_trap = 0; m_act = 0; m_ack = 0; m_err = 0; m_epc = '0;
      n_act = 0; n_epc = '0;
    end else if (m_trap) begin
      e_sel = 2'd2; e_tgt = TVEC; e_fl = rng(1, 1);
    end else if (m_held > 0) begin
      if (MIO_ready) ;
      else if (m_held >= WMAX) tmo = 1;
      else begin
        e_en = ~rng(0, MEMS); e_fl = rng(MEMS + 1, MEMS + 1); n_held = m_held + 1;
      end
    end else if (mem_req && !MIO_ready) begin
      e_en = ~rng(0, MEMS); e_fl = rng(MEMS + 1, MEMS + 1); n_held = 1;
    end else if (redirect_valid) begin
      e_fl = rng(1, DEC + 1); e_sel = 2'd1; e_tgt = redirect_pc;
    end else if (mret_valid && m_act) begin
      e_fl = rng(1, DEC + 1); e_sel = 2'd3; e_tgt = m_epc; n_act = 0;
    end else if (INT && !m_act && ex_valid) begin
      e_fl = rng(1, DEC + 1); e_en[0] = 1'b0; acc = 1; n_trap = 1;
      n_act = 1; n_epc = ex_pc;
    end else if (load_use_hzd) begin
      e_en = ~rng(0, DEC); e_fl = rng(DEC + 1, DEC + 1);
    end
    chk("stage_en", 32'(stage_en), 32'(e_en));
    chk("stage_flush", 32'(stage_flush), 32'(e_fl));
    chk("pc_sel", 32'(pc_sel), 32'(e_sel));
    chk("pc_target", pc_target, e_tgt);
    chk("epc", epc, m_epc);
    chk("int_active", 32'(int_active), 32'(m_act));
    chk("int_ack", 32'(int_ack), 32'(m_ack));
    chk("bus_err", 32'(bus_err), 32'(m_err));
    if (reset) begin
      m_held = n_held; m_trap = n_trap; m_act = n_act; m_epc = n_epc;
      m_ack = acc; m_err = tmo;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    load_use_hzd = 0; redirect_valid = 0; redirect_pc = '0; mret_valid = 0;
    ex_valid = 0; ex_pc = '0; mem_req = 0; MIO_ready = 1; INT = 0;
  endtask

  initial begin
    reset = 0; idle();
    repeat (3) cyc();
    #1;
    chk("rst_en", 32'(stage_en), 32'h00);
    chk("rst_fl", 32'(stage_flush), 32'h1f);
    cyc(); reset = 1; #1;
    chk("run_en", 32'(stage_en), 32'h1f);
    chk("run_epc", epc, 32'h0);

    // load-use
    cyc(); load_use_hzd = 1; #1;
    chk("lu_en", 32'(stage_en), 32'h1c);
    chk("lu_fl", 32'(stage_flush), 32'h04);
    cyc(); idle();

    // short bus wait, released on cycle 4
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_req = 1; MIO_ready = 0; #1;
      chk("bw_en", 32'(stage_en), 32'h10);
      chk("bw_fl", 32'(stage_flush), 32'h10);
    end
    cyc(); MIO_ready = 1; #1;
    chk("bw_rel", 32'(stage_en), 32'h1f);
    cyc(); idle();

    // timeout after WAIT_MAX held cycles
    for (int i = 0; i < WMAX; i++) begin
      cyc(); mem_req = 1; MIO_ready = 0; #1;
      chk("to_hold", 32'(stage_en), 32'h10);
    end
    cyc(); mem_req = 0; #1;
    chk("to_rel", 32'(stage_en), 32'h1f);
    chk("to_nerr", 32'(bus_err), 32'h0);
    cyc(); idle(); #1;
    chk("to_err", 32'(bus_err), 32'h1);
    cyc(); #1;
    chk("to_err_clr", 32'(bus_err), 32'h0);

    // interrupt entry
    cyc(); INT = 1; ex_valid = 1; ex_pc = 32'h40; #1;
    chk("int_fl", 32'(stage_flush), 32'h06);
    chk("int_en", 32'(stage_en), 32'h1e);
    cyc(); idle(); #1;
    chk("trap_sel", 32'(pc_sel), 32'h2);
    chk("trap_tgt", pc_target, 32'h100);
    chk("trap_ack", 32'(int_ack), 32'h1);
    chk("trap_epc", epc, 32'h40);
    chk("trap_act", 32'(int_active), 32'h1);
    cyc(); #1;
    chk("ack_clr", 32'(int_ack), 32'h0);

    // bus wait masks a redirect
    cyc(); mem_req = 1; MIO_ready = 0; redirect_valid = 1; redirect_pc = 32'h300; #1;
    chk("bw_redir_sel", 32'(pc_sel), 32'h0);
    cyc(); MIO_ready = 1; #1;
    cyc(); idle();

    // return from handler
    cyc(); mret_valid = 1; #1;
    chk("mret_sel", 32'(pc_sel), 32'h3);
    chk("mret_tgt", pc_target, 32'h40);
    cyc(); idle(); #1;
    chk("mret_act", 32'(int_active), 32'h0);

    // mret outside a handler is a NOP
    cyc(); mret_valid = 1; #1;
    chk("mret_nop", 32'(pc_sel), 32'h0);
    cyc(); idle();

    // redirect beats INT, INT taken next cycle
    cyc(); redirect_valid = 1; redirect_pc = 32'h200; INT = 1; ex_valid = 1; ex_pc = 32'h80; #1;
    chk("rd_sel", 32'(pc_sel), 32'h1);
    chk("rd_tgt", pc_target, 32'h200);
    cyc(); redirect_valid = 0; ex_pc = 32'h84; #1;
    chk("rd_int_fl", 32'(stage_flush), 32'h06);
    cyc(); INT = 0; #1;
    chk("rd_epc", epc, 32'h84);
    cyc(); mret_valid = 1; #1;
    cyc(); idle();

    // reset mid-wait: no bus_err afterwards
    for (int i = 0; i < 3; i++) begin cyc(); mem_req = 1; MIO_ready = 0; end
    cyc(); idle(); reset = 0;
    cyc(); reset = 1;
    repeat (2) begin cyc(); #1; chk("rst_wait_err", 32'(bus_err), 32'h0); end

    // reset mid-trap: no residual ack
    cyc(); INT = 1; ex_valid = 1; ex_pc = 32'h44;
    cyc(); idle(); reset = 0; #1;
    chk("rst_trap_ack", 32'(int_ack), 32'h0);
    cyc(); reset = 1; #1;
    chk("rst_trap_act", 32'(int_active), 32'h0);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
